// File: rtl/dcache_mem_ctrl_pkg.sv
// Shared definitions for the data-cache memory responder: FSM state encoding
// and the default line geometry, also imported by the data cache itself.
package dcache_mem_ctrl_pkg;

    localparam int DEFAULT_BLOCK_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/dcache_mem_ctrl_if.sv
// Line-miss bus between the data cache and its memory responder, together
// with the byte-wide single-port RAM port the responder drives.
interface dcache_mem_ctrl_if
    import dcache_mem_ctrl_pkg::*;
#(
    parameter int BLOCK_WIDTH = DEFAULT_BLOCK_WIDTH
);
    localparam int BLOCK_SIZE = 2 ** BLOCK_WIDTH;

    logic                      missIn;
    logic [31:BLOCK_WIDTH]     missAddrIn;
    logic                      readWriteIn;
    logic [BLOCK_SIZE*8-1:0]   writeBackIn;
    logic                      memDataValid;
    logic [31:BLOCK_WIDTH]     memAddr;
    logic [BLOCK_SIZE*8-1:0]   memDataOut;
    logic                      acceptWrite;
    logic                      busy;
    logic [31:0]               ramAddr;
    logic                      ramWrite;
    logic [7:0]                ramDataOut;
    logic [7:0]                ramDataIn;

    // The master side plays both the cache and the RAM.
    modport master (
        output missIn, missAddrIn, readWriteIn, writeBackIn, ramDataIn,
        input  memDataValid, memAddr, memDataOut, acceptWrite, busy,
               ramAddr, ramWrite, ramDataOut
    );

    modport slave (
        input  missIn, missAddrIn, readWriteIn, writeBackIn, ramDataIn,
        output memDataValid, memAddr, memDataOut, acceptWrite, busy,
               ramAddr, ramWrite, ramDataOut
    );

endinterface

// File: rtl/dcache_mem_ctrl.sv
// Serialises one cache-line fill or write-back at a time into byte accesses
// on the RAM port, returning the line / acknowledging with a one-cycle pulse.
module dcache_mem_ctrl
    import dcache_mem_ctrl_pkg::*;
#(
    parameter int BLOCK_WIDTH = DEFAULT_BLOCK_WIDTH,
    parameter int BLOCK_SIZE  = 2 ** BLOCK_WIDTH
) (
    input  logic              clkIn,
    input  logic              resetIn,
    dcache_mem_ctrl_if.slave  bus
);
    typedef logic [BLOCK_WIDTH:0] cnt_t;

    state_t                    r_state;
    cnt_t                      r_cnt;
    logic [31:BLOCK_WIDTH]     r_line;
    logic [BLOCK_SIZE*8-1:0]   r_wb;
    logic [BLOCK_SIZE*8-1:0]   r_fill;
    logic [BLOCK_SIZE*8-1:0]   r_mem_data;
    logic [31:BLOCK_WIDTH]     r_mem_addr;
    logic                      r_mem_valid;
    logic                      r_accept;
    logic                      r_busy;
    logic [31:0]               r_ram_addr;
    logic                      r_ram_write;
    logic [7:0]                r_ram_data;

    cnt_t                      w_cnt_next;
    logic                      w_read_last;
    logic                      w_write_last;
    logic [BLOCK_WIDTH-1:0]    w_cap_idx;
    logic [7:0]                w_wr_byte_next;
    logic [BLOCK_SIZE*8-1:0]   w_fill_done;

    assign w_cnt_next     = r_cnt + 1'b1;
    assign w_read_last    = (r_cnt == cnt_t'(BLOCK_SIZE));
    assign w_write_last   = (r_cnt == cnt_t'(BLOCK_SIZE - 1));
    // RAM data lags its address by a cycle, so cnt=k delivers byte k-1 (k=BLOCK_SIZE wraps to the last byte).
    assign w_cap_idx      = r_cnt[BLOCK_WIDTH-1:0] - 1'b1;
    assign w_wr_byte_next = r_wb[{w_cnt_next[BLOCK_WIDTH-1:0], 3'b000} +: 8];

    always_comb begin
        w_fill_done = r_fill;
        w_fill_done[{w_cap_idx, 3'b000} +: 8] = bus.ramDataIn;
    end

    // NOTE: every register here uses non-blocking assignment so all of them update
    // together from the previous cycle's values, whatever order the statements run in.
    always_ff @(posedge clkIn or posedge resetIn) begin
        if (resetIn) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_line      <= '0;
            r_wb        <= '0;
            r_fill      <= '0;
            r_mem_data  <= '0;
            r_mem_addr  <= '0;
            r_mem_valid <= 1'b0;
            r_accept    <= 1'b0;
            r_busy      <= 1'b0;
            r_ram_addr  <= '0;
            r_ram_write <= 1'b0;
            r_ram_data  <= '0;
        end else begin
            r_mem_valid <= 1'b0;
            r_accept    <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (bus.missIn) begin
                        r_line      <= bus.missAddrIn;
                        r_wb        <= bus.writeBackIn;
                        r_cnt       <= '0;
                        r_busy      <= 1'b1;
                        r_ram_addr  <= {bus.missAddrIn, {BLOCK_WIDTH{1'b0}}};
                        r_ram_write <= ~bus.readWriteIn;
                        r_ram_data  <= bus.readWriteIn ? 8'h00 : bus.writeBackIn[7:0];
                        r_state     <= bus.readWriteIn ? READ : WRITE;
                    end
                end
                READ: begin
                    if (r_cnt != '0) begin
                        r_fill <= w_fill_done;
                    end
                    if (w_read_last) begin
                        r_mem_data  <= w_fill_done;
                        r_mem_valid <= 1'b1;
                        r_mem_addr  <= r_line;
                        r_ram_addr  <= '0;
                        r_state     <= DONE;
                    end else begin
                        r_cnt <= w_cnt_next;
                        if (w_cnt_next != cnt_t'(BLOCK_SIZE)) begin
                            r_ram_addr <= {r_line, w_cnt_next[BLOCK_WIDTH-1:0]};
                        end
                    end
                end
                WRITE: begin
                    if (w_write_last) begin
                        r_accept    <= 1'b1;
                        r_mem_addr  <= r_line;
                        r_ram_write <= 1'b0;
                        r_ram_addr  <= '0;
                        r_ram_data  <= '0;
                        r_state     <= DONE;
                    end else begin
                        r_cnt      <= w_cnt_next;
                        r_ram_addr <= {r_line, w_cnt_next[BLOCK_WIDTH-1:0]};
                        r_ram_data <= w_wr_byte_next;
                    end
                end
                DONE: begin
                    // missIn is deliberately not sampled here: the cache is still reacting to the pulse.
                    r_busy  <= 1'b0;
                    r_cnt   <= '0;
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.memDataValid = r_mem_valid;
    assign bus.memAddr      = r_mem_addr;
    assign bus.memDataOut   = r_mem_data;
    assign bus.acceptWrite  = r_accept;
    assign bus.busy         = r_busy;
    assign bus.ramAddr      = r_ram_addr;
    assign bus.ramWrite     = r_ram_write;
    assign bus.ramDataOut   = r_ram_data;

endmodule

// File: tb/tb_dcache_mem_ctrl.sv
// Directed plus randomized bench for dcache_mem_ctrl; a byte-level RAM image
// and a request-level memory model supply every expected value.
module tb_dcache_mem_ctrl;
    import dcache_mem_ctrl_pkg::*;

    localparam int BW = DEFAULT_BLOCK_WIDTH;
    localparam int BS = 2 ** BW;

    logic clk = 1'b0;
    logic rst;
    int   n_assert = 0;
    int   n_fail   = 0;

    // RAM behind the DUT, aliased on the low 12 address bits; unwritten bytes read as addr[7:0].
    bit [7:0] ram      [4096];
    bit       ram_wr   [4096];
    // Reference memory, updated only at request level by the stimulus.
    bit [7:0] model_mem[4096];
    bit       model_wr [4096];

    dcache_mem_ctrl_if #(.BLOCK_WIDTH(BW)) bus();

    dcache_mem_ctrl #(.BLOCK_WIDTH(BW)) dut (
        .clkIn   (clk),
        .resetIn (rst),
        .bus     (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] ram_rd(input logic [31:0] a);
        return ram_wr[a[11:0]] ? ram[a[11:0]] : a[7:0];
    endfunction

    always @(posedge clk) begin
        if (bus.ramWrite) begin
            ram[bus.ramAddr[11:0]]    <= bus.ramDataOut;
            ram_wr[bus.ramAddr[11:0]] <= 1'b1;
        end
        bus.ramDataIn <= ram_rd(bus.ramAddr);
    end

    function automatic logic [7:0] model_rd(input logic [31:0] a);
        return model_wr[a[11:0]] ? model_mem[a[11:0]] : a[7:0];
    endfunction

    function automatic logic [127:0] model_line(input logic [27:0] line);
        logic [127:0] l;
        for (int k = 0; k < BS; k++) l[8*k +: 8] = model_rd({line, 4'(k)});
        return l;
    endfunction

    task automatic model_write(input logic [27:0] line, input logic [127:0] data, input int nbytes);
        logic [31:0] a;
        for (int k = 0; k < nbytes; k++) begin
            a = {line, 4'(k)};
            model_mem[a[11:0]] = data[8*k +: 8];
            model_wr[a[11:0]]  = 1'b1;
        end
    endtask

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_ram_line(input logic [27:0] line);
        for (int k = 0; k < BS; k++)
            check("ram_content", ram_rd({line, 4'(k)}), model_rd({line, 4'(k)}));
    endtask

    // Current cycle is the one in which the fill request is sampled.
    task automatic fill_run(input logic [27:0] line);
        logic [127:0] exp_line;
        exp_line = model_line(line);
        for (int k = 0; k < BS; k++) begin
            step();
            check("fill_ram_addr", bus.ramAddr, {line, 4'(k)});
            check("fill_ram_write", bus.ramWrite, 1'b0);
            check("fill_ram_data", bus.ramDataOut, 8'h00);
            check("fill_no_pulse", {bus.memDataValid, bus.acceptWrite}, 2'b00);
        end
        step();
        check("fill_addr_hold", bus.ramAddr, {line, 4'hF});
        check("fill_early_valid", bus.memDataValid, 1'b0);
        check("fill_busy", bus.busy, 1'b1);
        step();
        check("fill_valid", bus.memDataValid, 1'b1);
        check("fill_no_accept", bus.acceptWrite, 1'b0);
        check("fill_data", bus.memDataOut, exp_line);
        check("fill_mem_addr", bus.memAddr, line);
        check("fill_done_ram_addr", bus.ramAddr, 32'h0);
        bus.missIn = 1'b0;
        step();
        check("fill_pulse_width", bus.memDataValid, 1'b0);
        check("fill_idle_busy", bus.busy, 1'b0);
        check("fill_data_hold", bus.memDataOut, exp_line);
    endtask

    task automatic do_fill(input logic [27:0] line);
        bus.missIn      = 1'b1;
        bus.readWriteIn = 1'b1;
        bus.missAddrIn  = line;
        bus.writeBackIn = {$urandom, $urandom, $urandom, $urandom};
        fill_run(line);
    endtask

    // Returns in the DONE cycle when hold is set, otherwise in the following IDLE cycle.
    task automatic do_wb(input logic [27:0] line, input logic [127:0] data, input bit hold);
        bus.missIn      = 1'b1;
        bus.readWriteIn = 1'b0;
        bus.missAddrIn  = line;
        bus.writeBackIn = data;
        for (int k = 0; k < BS; k++) begin
            step();
            if (k == 0) bus.writeBackIn = ~data;
            check("wb_ram_write", bus.ramWrite, 1'b1);
            check("wb_ram_addr", bus.ramAddr, {line, 4'(k)});
            check("wb_ram_data", bus.ramDataOut, data[8*k +: 8]);
            check("wb_no_pulse", {bus.memDataValid, bus.acceptWrite}, 2'b00);
        end
        step();
        check("wb_accept", bus.acceptWrite, 1'b1);
        check("wb_no_valid", bus.memDataValid, 1'b0);
        check("wb_mem_addr", bus.memAddr, line);
        check("wb_done_ram", {bus.ramWrite, bus.ramAddr, bus.ramDataOut}, 41'h0);
        model_write(line, data, BS);
        check_ram_line(line);
        if (!hold) begin
            bus.missIn = 1'b0;
            step();
            check("wb_pulse_width", bus.acceptWrite, 1'b0);
            check("wb_idle_busy", bus.busy, 1'b0);
        end
    endtask

    initial begin
        logic [27:0]  line_a;
        logic [27:0]  line_b;
        logic [127:0] data;

        rst             = 1'b1;
        bus.missIn      = 1'b0;
        bus.readWriteIn = 1'b0;
        bus.missAddrIn  = '0;
        bus.writeBackIn = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset_flags", {bus.busy, bus.memDataValid, bus.acceptWrite, bus.ramWrite}, 4'h0);
        check("reset_ram_bus", {bus.ramAddr, bus.ramDataOut}, 40'h0);
        check("reset_mem_addr", bus.memAddr, 28'h0);
        check("reset_mem_data", bus.memDataOut, 128'h0);
        rst = 1'b0;
        step();

        do_fill(28'h0000010);
        check("fill_0x10_line", bus.memDataOut, 128'h0F0E0D0C0B0A09080706050403020100);

        do_wb(28'h0000020, 128'hFFEEDDCCBBAA99887766554433221100, 1'b0);

        // Write-back held on missIn, then the same request switches to a fill of another line.
        line_a = {20'($urandom), 8'h41};
        line_b = {20'($urandom), 8'h52};
        do_wb(line_a, {$urandom, $urandom, $urandom, $urandom}, 1'b1);
        bus.readWriteIn = 1'b1;
        bus.missAddrIn  = line_b;
        step();
        check("b2b_idle_gap", {bus.busy, bus.ramWrite, bus.acceptWrite, bus.memDataValid}, 4'h0);
        fill_run(line_b);
        repeat (3) begin
            step();
            check("b2b_no_reservice", {bus.busy, bus.ramWrite}, 2'b00);
        end
        do_fill(line_a);

        do_fill(28'hFFFFFFF);
        check("wrap_mem_addr", bus.memAddr, 28'hFFFFFFF);

        // Asynchronous reset while byte 7 of a write-back is on the bus.
        line_a = 28'h0000060;
        data   = {$urandom, $urandom, $urandom, $urandom};
        bus.missIn      = 1'b1;
        bus.readWriteIn = 1'b0;
        bus.missAddrIn  = line_a;
        bus.writeBackIn = data;
        for (int k = 0; k < 8; k++) begin
            step();
            check("abort_ram_addr", bus.ramAddr, {line_a, 4'(k)});
        end
        #2 rst = 1'b1;
        #1;
        check("abort_flags", {bus.ramWrite, bus.busy, bus.acceptWrite, bus.memDataValid}, 4'h0);
        check("abort_ram_bus", {bus.ramAddr, bus.ramDataOut}, 40'h0);
        check("abort_mem_data", bus.memDataOut, 128'h0);
        bus.missIn = 1'b0;
        model_write(line_a, data, 7);
        step();
        rst = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            check("abort_quiet", {bus.acceptWrite, bus.busy, bus.ramWrite}, 3'b000);
        end
        check_ram_line(line_a);
        do_fill(line_a);

        // Random mix on a few aliasing line slots, so fills read back earlier write-backs.
        for (int i = 0; i < 12; i++) begin
            line_a = {20'($urandom), 8'(8'h30 + $urandom_range(0, 3))};
            if ($urandom_range(0, 1) == 1) do_fill(line_a);
            else do_wb(line_a, {$urandom, $urandom, $urandom, $urandom}, 1'b0);
            repeat ($urandom_range(0, 2)) begin
                step();
                check("rand_idle", bus.busy, 1'b0);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no end of test, required finish before 200000 ns");
        $fatal(1, "watchdog expired");
    end

endmodule
